// File: rtl/vec_add_seq_pkg.sv
// Shared definitions for the vector-add element sequencer: default widths,
// FSM state encoding and a small state-classification helper.
package vec_add_seq_pkg;

   // Default element width (matches the scalar adder operand width).
   localparam int DATA_W_DEF = 32;

   // Default memory index width; maximum vector length is 2**ADDR_W.
   localparam int ADDR_W_DEF = 8;

   // Sequencer states. Encoding is fixed so traces and probes stay readable.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } state_t;

   // True for every state in which a vector is being processed.
   function automatic logic is_busy_state(input state_t s);
      return (s == READ) || (s == ISSUE) || (s == WAIT) || (s == DRAIN);
   endfunction

endpackage

// File: rtl/vec_add_seq.sv
// Element sequencer for c = a + b over vectors. Walks an index through two
// synchronous-read operand memories, hands each pair to a scalar adder with a
// ready/valid/accept handshake, and writes each sum back to memory C at the
// same index. WAIT and DRAIN are driven purely by add_valid, so the adder's
// internal latency and its post-accept valid tail never matter here.
module vec_add_seq
   import vec_add_seq_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_a_rdata,
   input  logic [DATA_W-1:0] mem_b_rdata,
   output logic [DATA_W-1:0] mem_c_wdata,
   output logic              mem_c_we,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic              add_ready,
   input  logic              add_valid,
   input  logic [DATA_W-1:0] c,
   output logic              add_accept
);

   localparam logic [ADDR_W:0]   LEN_ONE = 1;
   localparam logic [ADDR_W-1:0] IDX_ONE = 1;

   // FSM and index state
   state_t              r_state;
   logic [ADDR_W-1:0]   r_idx;
   logic [ADDR_W:0]     r_len;

   // Registered outputs
   logic                r_busy;
   logic                r_done;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_c_wdata;
   logic                r_mem_c_we;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic                r_add_ready;
   logic                r_add_accept;

   // Next-state values shared by the FSM and the output registers
   state_t              w_state_next;
   logic [ADDR_W-1:0]   w_idx_next;
   logic                w_last;
   logic                w_accept;

   // The current element is the final one when idx == len-1.
   assign w_last   = ({1'b0, r_idx} == (r_len - LEN_ONE));

   // A result is taken exactly once: on the first add_valid seen in WAIT.
   assign w_accept = (r_state == WAIT) && add_valid;

   // Next-state and next-index decode; start is honoured only in IDLE.
   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  w_state_next = READ;
                  w_idx_next   = '0;
               end else begin
                  w_state_next = DONE;
               end
            end
         end
         READ:  w_state_next = ISSUE;
         ISSUE: w_state_next = WAIT;
         WAIT: begin
            if (add_valid) begin
               w_state_next = DRAIN;
            end
         end
         DRAIN: begin
            // The adder holds valid for a while after the accept; wait for
            // it to fall so the tail is never mistaken for a new result.
            if (!add_valid) begin
               if (w_last) begin
                  w_state_next = DONE;
               end else begin
                  w_state_next = READ;
                  w_idx_next   = r_idx + IDX_ONE;
               end
            end
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // FSM state, element index and latched vector length.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_len   <= '0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
         if ((r_state == IDLE) && start) begin
            r_len <= len;
         end
      end
   end

   // Registered outputs: memory index, operands, handshake strobes and status.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_c_wdata <= '0;
         r_mem_c_we    <= 1'b0;
         r_a           <= '0;
         r_b           <= '0;
         r_add_ready   <= 1'b0;
         r_add_accept  <= 1'b0;
      end else begin
         r_busy <= is_busy_state(w_state_next);
         r_done <= (r_state == DONE);

         // Index is loaded on entry to READ and then held through DRAIN so
         // the C write lands on the same address the operands came from.
         if (w_state_next == READ) begin
            r_mem_addr <= w_idx_next;
         end

         // RAM data for the address presented in READ is valid in ISSUE.
         if (r_state == ISSUE) begin
            r_a <= mem_a_rdata;
            r_b <= mem_b_rdata;
         end

         r_add_ready  <= (r_state == ISSUE);
         r_add_accept <= w_accept;
         r_mem_c_we   <= w_accept;
         if (w_accept) begin
            r_mem_c_wdata <= c;
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign mem_addr    = r_mem_addr;
   assign mem_c_wdata = r_mem_c_wdata;
   assign mem_c_we    = r_mem_c_we;
   assign a           = r_a;
   assign b           = r_b;
   assign add_ready   = r_add_ready;
   assign add_accept  = r_add_accept;

endmodule

// File: tb/tb_vec_add_seq.sv
// Directed testbench for vec_add_seq: behavioural operand RAMs, a behavioural
// adder with programmable result latency and post-accept valid tail, and a
// negedge monitor that logs strobes and C writes.
module tb_vec_add_seq;

   localparam int DW = 32;
   localparam int AW = 8;

   logic          clk   = 1'b0;
   logic          rst   = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   len   = '0;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_a_rdata;
   logic [DW-1:0] mem_b_rdata;
   logic [DW-1:0] mem_c_wdata;
   logic          mem_c_we;
   logic [DW-1:0] a;
   logic [DW-1:0] b;
   logic          add_ready;
   logic          add_valid;
   logic [DW-1:0] c;
   logic          add_accept;

   int checks = 0;
   int errors = 0;

   vec_add_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .mem_addr   (mem_addr),
      .mem_a_rdata(mem_a_rdata),
      .mem_b_rdata(mem_b_rdata),
      .mem_c_wdata(mem_c_wdata),
      .mem_c_we   (mem_c_we),
      .a          (a),
      .b          (b),
      .add_ready  (add_ready),
      .add_valid  (add_valid),
      .c          (c),
      .add_accept (add_accept)
   );

   always #5 clk = ~clk;

   // Synchronous-read operand memories
   logic [DW-1:0] mem_a [0:255];
   logic [DW-1:0] mem_b [0:255];

   always @(posedge clk) begin
      mem_a_rdata <= mem_a[mem_addr];
      mem_b_rdata <= mem_b[mem_addr];
   end

   // Behavioural adder: valid rises lat edges after it samples add_ready,
   // waits for accept, then keeps valid high for hold more edges.
   int            lat = 2;
   int            hold = 1;
   int            m_state = 0;
   int            m_cnt = 0;
   logic [DW-1:0] m_sum;
   int            proto_err = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_state   <= 0;
         m_cnt     <= 0;
         m_sum     <= '0;
         add_valid <= 1'b0;
         c         <= '0;
      end else begin
         case (m_state)
            0: begin
               if (add_ready) begin
                  m_sum   <= a + b;
                  m_cnt   <= lat - 1;
                  m_state <= 1;
               end
            end
            1: begin
               if (add_ready) proto_err <= proto_err + 1;
               if (m_cnt == 0) begin
                  add_valid <= 1'b1;
                  c         <= m_sum;
                  m_state   <= 2;
               end else begin
                  m_cnt <= m_cnt - 1;
               end
            end
            2: begin
               if (add_ready) proto_err <= proto_err + 1;
               if (add_accept) begin
                  m_cnt   <= hold - 1;
                  m_state <= 3;
               end
            end
            3: begin
               if (add_ready || add_accept) proto_err <= proto_err + 1;
               if (m_cnt == 0) begin
                  add_valid <= 1'b0;
                  m_state   <= 0;
               end else begin
                  m_cnt <= m_cnt - 1;
               end
            end
            default: m_state <= 0;
         endcase
      end
   end

   // Monitor
   int            cyc = 0;
   int            done_cnt = 0;
   int            done_cyc = 0;
   int            ready_cnt = 0;
   int            accept_cnt = 0;
   int            busy_cnt = 0;
   int            pulse_err = 0;
   logic          prev_ready = 1'b0;
   logic          prev_accept = 1'b0;
   logic          prev_we = 1'b0;
   logic [AW-1:0] wa_q [$];
   logic [DW-1:0] wd_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc + 1;
      end
      if (add_ready)  ready_cnt  <= ready_cnt + 1;
      if (add_accept) accept_cnt <= accept_cnt + 1;
      if (busy)       busy_cnt   <= busy_cnt + 1;
      if (mem_c_we) begin
         wa_q.push_back(mem_addr);
         wd_q.push_back(mem_c_wdata);
      end
      if ((add_ready && prev_ready) || (add_accept && prev_accept) || (mem_c_we && prev_we))
         pulse_err <= pulse_err + 1;
      prev_ready  <= add_ready;
      prev_accept <= add_accept;
      prev_we     <= mem_c_we;
   end

   // Starts a vector of n elements and waits (bounded) for done. Optionally
   // pulses start with len=1 at loop step poke_at while the run is busy.
   task automatic run_vec(input int n, input int budget, input int poke_at,
                          output int latency, output bit ok);
      int d0;
      int t0;
      d0 = done_cnt;
      start = 1'b1;
      len = n[AW:0];
      @(posedge clk);
      @(negedge clk); #1;
      t0 = cyc;
      start = 1'b0;
      len = '0;
      for (int i = 0; i < budget && done_cnt == d0; i++) begin
         if (i == poke_at) begin
            start = 1'b1;
            len = 1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk); #1;
      end
      start = 1'b0;
      len = '0;
      ok = (done_cnt != d0);
      latency = done_cyc - t0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk); #1;
      checks++;
      if ({busy, done, mem_addr, mem_c_wdata, mem_c_we, a, b, add_ready, add_accept} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %0h exp 0",
                  {busy, done, mem_addr, mem_c_wdata, mem_c_we, a, b, add_ready, add_accept});
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({busy, done, add_ready, mem_c_we} !== 4'b0) begin
         errors++;
         $display("FAIL idle_after_reset got %0b exp 0", {busy, done, add_ready, mem_c_we});
      end
   endtask

   task automatic test_basic();
      logic [DW-1:0] exp_c [4];
      int q0, r0, a0, p0, e0, d0, latency;
      bit ok;
      exp_c = '{32'd11, 32'd22, 32'd33, 32'd44};
      for (int k = 0; k < 4; k++) begin
         mem_a[k] = (k + 1);
         mem_b[k] = 10 * (k + 1);
      end
      q0 = wa_q.size(); r0 = ready_cnt; a0 = accept_cnt;
      p0 = pulse_err; e0 = proto_err; d0 = done_cnt;
      run_vec(4, 200, -1, latency, ok);
      repeat (4) @(negedge clk);
      #1;
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_done_timeout got 0 exp 1"); end
      checks++;
      if (latency != 38) begin errors++; $display("FAIL basic_latency got %0d exp 38", latency); end
      checks++;
      if (wa_q.size() - q0 != 4) begin errors++; $display("FAIL basic_writes got %0d exp 4", wa_q.size() - q0); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ((q0 + k >= wa_q.size()) || (wa_q[q0+k] !== k[AW-1:0])) begin
            errors++; $display("FAIL basic_addr%0d got %0d exp %0d", k, (q0 + k < wa_q.size()) ? wa_q[q0+k] : '1, k);
         end
         checks++;
         if ((q0 + k >= wd_q.size()) || (wd_q[q0+k] !== exp_c[k])) begin
            errors++; $display("FAIL basic_data%0d got %0d exp %0d", k, (q0 + k < wd_q.size()) ? wd_q[q0+k] : '1, exp_c[k]);
         end
      end
      checks++;
      if (ready_cnt - r0 != 4) begin errors++; $display("FAIL basic_ready_count got %0d exp 4", ready_cnt - r0); end
      checks++;
      if (accept_cnt - a0 != 4) begin errors++; $display("FAIL basic_accept_count got %0d exp 4", accept_cnt - a0); end
      checks++;
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", done_cnt - d0); end
      checks++;
      if ((pulse_err != p0) || (proto_err != e0)) begin
         errors++; $display("FAIL basic_pulse_width got %0d exp 0", (pulse_err - p0) + (proto_err - e0));
      end
   endtask

   task automatic test_len_zero();
      int q0, r0, b0, latency;
      bit ok;
      q0 = wa_q.size(); r0 = ready_cnt; b0 = busy_cnt;
      run_vec(0, 20, -1, latency, ok);
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (!ok) begin errors++; $display("FAIL zero_done_timeout got 0 exp 1"); end
      checks++;
      if (latency != 2) begin errors++; $display("FAIL zero_latency got %0d exp 2", latency); end
      checks++;
      if ((ready_cnt - r0) + (wa_q.size() - q0) != 0) begin
         errors++; $display("FAIL zero_activity got %0d exp 0", (ready_cnt - r0) + (wa_q.size() - q0));
      end
      checks++;
      if (busy_cnt != b0) begin errors++; $display("FAIL zero_busy got %0d exp 0", busy_cnt - b0); end
   endtask

   task automatic test_wrap();
      int q0, r0, a0, latency;
      bit ok;
      mem_a[0] = 32'hFFFF_FFFF;
      mem_b[0] = 32'd1;
      q0 = wa_q.size(); r0 = ready_cnt; a0 = accept_cnt;
      run_vec(1, 50, -1, latency, ok);
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (!ok || latency != 11) begin errors++; $display("FAIL wrap_latency got %0d exp 11", latency); end
      checks++;
      if (wa_q.size() - q0 != 1) begin errors++; $display("FAIL wrap_writes got %0d exp 1", wa_q.size() - q0); end
      checks++;
      if ((q0 >= wd_q.size()) || (wd_q[q0] !== 32'd0) || (wa_q[q0] !== 8'd0)) begin
         errors++; $display("FAIL wrap_data got %0h exp 0", (q0 < wd_q.size()) ? wd_q[q0] : '1);
      end
      checks++;
      if ((ready_cnt - r0 != 1) || (accept_cnt - a0 != 1)) begin
         errors++; $display("FAIL wrap_handshakes got %0d/%0d exp 1/1", ready_cnt - r0, accept_cnt - a0);
      end
   endtask

   task automatic test_slow_adder();
      logic [DW-1:0] exp_c [2];
      int q0, a0, e0, p0, latency;
      bit ok;
      exp_c = '{32'd1, 32'd16};
      mem_a[0] = 32'h8000_0000; mem_b[0] = 32'h8000_0001;
      mem_a[1] = 32'd7;         mem_b[1] = 32'd9;
      lat = 20; hold = 5;
      q0 = wa_q.size(); a0 = accept_cnt; e0 = proto_err; p0 = pulse_err;
      run_vec(2, 300, -1, latency, ok);
      repeat (10) @(negedge clk);
      #1;
      lat = 2; hold = 1;
      checks++;
      if (!ok || latency != 64) begin errors++; $display("FAIL slow_latency got %0d exp 64", latency); end
      checks++;
      if (wa_q.size() - q0 != 2) begin errors++; $display("FAIL slow_writes got %0d exp 2", wa_q.size() - q0); end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ((q0 + k >= wd_q.size()) || (wd_q[q0+k] !== exp_c[k]) || (wa_q[q0+k] !== k[AW-1:0])) begin
            errors++; $display("FAIL slow_data%0d got %0d exp %0d", k, (q0 + k < wd_q.size()) ? wd_q[q0+k] : '1, exp_c[k]);
         end
      end
      checks++;
      if (accept_cnt - a0 != 2) begin errors++; $display("FAIL slow_accept_count got %0d exp 2", accept_cnt - a0); end
      checks++;
      if ((proto_err != e0) || (pulse_err != p0)) begin
         errors++; $display("FAIL slow_duplicate got %0d exp 0", (proto_err - e0) + (pulse_err - p0));
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] exp_c [3];
      int q0, d0, latency;
      bit ok;
      bit found;
      exp_c = '{32'd1001, 32'd2002, 32'd3003};
      for (int k = 0; k < 4; k++) begin
         mem_a[k] = 1000 * (k + 1);
         mem_b[k] = (k + 1);
      end
      q0 = wa_q.size(); d0 = done_cnt;
      found = 1'b0;
      start = 1'b1; len = 4;
      @(posedge clk);
      @(negedge clk); #1;
      start = 1'b0; len = '0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (add_ready && mem_addr == 8'd2) found = 1'b1;
         else begin @(negedge clk); #1; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL rstmid_reach_wait got 0 exp 1"); end
      checks++;
      if (wa_q.size() - q0 != 2) begin errors++; $display("FAIL rstmid_prior_writes got %0d exp 2", wa_q.size() - q0); end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({busy, done, mem_addr, mem_c_wdata, mem_c_we, a, b, add_ready, add_accept} !== '0) begin
         errors++;
         $display("FAIL rstmid_async_clear got %0h exp 0",
                  {busy, done, mem_addr, mem_c_wdata, mem_c_we, a, b, add_ready, add_accept});
      end
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (done_cnt != d0) begin errors++; $display("FAIL rstmid_no_done got %0d exp 0", done_cnt - d0); end
      q0 = wa_q.size();
      run_vec(3, 200, -1, latency, ok);
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (!ok || latency != 29) begin errors++; $display("FAIL rstmid_rerun_latency got %0d exp 29", latency); end
      checks++;
      if (wa_q.size() - q0 != 3) begin errors++; $display("FAIL rstmid_rerun_writes got %0d exp 3", wa_q.size() - q0); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ((q0 + k >= wd_q.size()) || (wd_q[q0+k] !== exp_c[k]) || (wa_q[q0+k] !== k[AW-1:0])) begin
            errors++; $display("FAIL rstmid_data%0d got %0d exp %0d", k, (q0 + k < wd_q.size()) ? wd_q[q0+k] : '1, exp_c[k]);
         end
      end
   endtask

   task automatic test_restart_ignored();
      logic [DW-1:0] exp_c [3];
      int q0, d0, latency;
      bit ok;
      exp_c = '{32'd55, 32'd66, 32'd77};
      for (int k = 0; k < 3; k++) begin
         mem_a[k] = 5 + k;
         mem_b[k] = 50 + 10 * k;
      end
      q0 = wa_q.size(); d0 = done_cnt;
      run_vec(3, 200, 10, latency, ok);
      repeat (20) @(negedge clk);
      #1;
      checks++;
      if (!ok || latency != 29) begin errors++; $display("FAIL restart_latency got %0d exp 29", latency); end
      checks++;
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL restart_done_count got %0d exp 1", done_cnt - d0); end
      checks++;
      if (wa_q.size() - q0 != 3) begin errors++; $display("FAIL restart_writes got %0d exp 3", wa_q.size() - q0); end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ((q0 + k >= wd_q.size()) || (wd_q[q0+k] !== exp_c[k]) || (wa_q[q0+k] !== k[AW-1:0])) begin
            errors++; $display("FAIL restart_data%0d got %0d exp %0d", k, (q0 + k < wd_q.size()) ? wd_q[q0+k] : '1, exp_c[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len_zero();
      test_wrap();
      test_slow_adder();
      test_reset_mid();
      test_restart_ignored();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "global timeout");
   end

endmodule
